// File: rtl/pkg_cpu.sv
// Shared spark80 CPU definitions: access-size encodings, RAM byte-enable
// constants and the memory-bridge state enum.
package pkg_cpu;

    // CPU data access size (data_acc_sz)
    localparam logic cpu_data_acc_sz_8  = 1'b0;
    localparam logic cpu_data_acc_sz_16 = 1'b1;

    // RAM byte enables: bit 0 -> [7:0] (even byte), bit 1 -> [15:8] (odd byte)
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAcc0,
        StWait0,
        StAcc1,
        StWait1,
        StDone
    } bridge_state_e;

    // A 16-bit access at an odd byte address straddles two RAM words.
    function automatic logic is_split(input logic acc_sz, input logic addr_lsb);
        return (acc_sz == cpu_data_acc_sz_16) && addr_lsb;
    endfunction

endpackage

// File: rtl/spark80_mem_bridge_if.sv
// spark80 memory-bridge bus bundle.
//   CPU side : req_rdwr, data_inout_addr, data_acc_sz, data_inout_we, temp_data_out (CPU -> bridge)
//              temp_data_in, data_ready (bridge -> CPU)
//   RAM side : ram_addr, ram_en, ram_we, ram_be, ram_wdata (bridge -> RAM), ram_rdata (RAM -> bridge)
// Modports: master = CPU, slave = bridge, ram = block RAM.
interface spark80_mem_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic                  req_rdwr;
    logic [ADDR_WIDTH-1:0] data_inout_addr;
    logic                  data_acc_sz;
    logic                  data_inout_we;
    logic [15:0]           temp_data_out;
    logic [15:0]           temp_data_in;
    logic                  data_ready;

    logic [ADDR_WIDTH-2:0] ram_addr;
    logic                  ram_en;
    logic                  ram_we;
    logic [1:0]            ram_be;
    logic [15:0]           ram_wdata;
    logic [15:0]           ram_rdata;

    modport master (
        output req_rdwr, data_inout_addr, data_acc_sz, data_inout_we, temp_data_out,
        input  temp_data_in, data_ready
    );

    modport slave (
        input  req_rdwr, data_inout_addr, data_acc_sz, data_inout_we, temp_data_out, ram_rdata,
        output temp_data_in, data_ready, ram_addr, ram_en, ram_we, ram_be, ram_wdata
    );

    modport ram (
        input  ram_addr, ram_en, ram_we, ram_be, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/spark80_byte_lane_steer.sv
// Combinational byte-lane steering between the CPU data path and the 16-bit RAM.
//   acc_sz_i      : access size (pkg_cpu encodings)
//   addr_lsb_i    : byte address bit 0 of the current access
//   second_half_i : 1 while working on the second word of a split access
//   cpu_wdata_i   : CPU write data
//   ram_rdata_i   : RAM read data
//   rd_prev_i     : partially assembled read result
//   ram_be_o      : byte enables for this word access
//   ram_wdata_o   : lane-steered write data
//   rd_next_o     : read result with this word's lane(s) merged in
module spark80_byte_lane_steer
    import pkg_cpu::*;
(
    input  logic        acc_sz_i,
    input  logic        addr_lsb_i,
    input  logic        second_half_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic [15:0] ram_rdata_i,
    input  logic [15:0] rd_prev_i,
    output logic [1:0]  ram_be_o,
    output logic [15:0] ram_wdata_o,
    output logic [15:0] rd_next_o
);

    always_comb begin
        ram_be_o    = BE_BOTH;
        ram_wdata_o = cpu_wdata_i;
        rd_next_o   = ram_rdata_i;
        if (acc_sz_i == cpu_data_acc_sz_8) begin
            // Byte data goes on both lanes; the enable picks the real one.
            ram_be_o    = addr_lsb_i ? BE_HI : BE_LO;
            ram_wdata_o = {2{cpu_wdata_i[7:0]}};
            rd_next_o   = {8'h00, (addr_lsb_i ? ram_rdata_i[15:8] : ram_rdata_i[7:0])};
        end else if (addr_lsb_i) begin
            // Split word: low CPU byte lives in lane 1 of the first word, high CPU byte
            // in lane 0 of the next, so a swapped word serves both halves.
            ram_wdata_o = {cpu_wdata_i[7:0], cpu_wdata_i[15:8]};
            if (!second_half_i) begin
                ram_be_o  = BE_HI;
                rd_next_o = {rd_prev_i[15:8], ram_rdata_i[15:8]};
            end else begin
                ram_be_o  = BE_LO;
                rd_next_o = {ram_rdata_i[7:0], rd_prev_i[7:0]};
            end
        end
    end

endmodule

// File: rtl/spark80_mem_bridge.sv
// Bridge between the spark80 CPU memory port and a 16-bit synchronous block RAM
// with byte enables. One request at a time; byte addresses become word addresses
// plus lane enables, and read data returns with a one-cycle data_ready.
//   clk, reset : clock and synchronous active-high reset
//   bus        : CPU and RAM signals (spark80_mem_bridge_if, slave modport)
//   misalign   : one-cycle pulse on a forced-aligned 16-bit access (only when
//                SPARK80_MEM_BRIDGE_UNALIGNED_EN is undefined)
// Build option: SPARK80_MEM_BRIDGE_UNALIGNED_EN defined splits odd 16-bit
// accesses into two word accesses; undefined forces them to the aligned word.
// ADDR_WIDTH must match the interface instance parameter.
module spark80_mem_bridge
    import pkg_cpu::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    spark80_mem_bridge_if.slave  bus
`ifndef SPARK80_MEM_BRIDGE_UNALIGNED_EN
    ,
    output logic                 misalign
`endif
);

    localparam int unsigned WordW      = ADDR_WIDTH - 1;
    localparam logic [3:0]  CntLoad    = 4'(RAM_LATENCY + WAIT_STATES - 1);
    localparam logic [3:0]  CntCapture = 4'(WAIT_STATES);

    bridge_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  sz_q, sz_d;
    logic                  we_q, we_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           acc_q, acc_d;     // read result being assembled
    logic [15:0]           rdata_q, rdata_d; // read result presented to the CPU
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
    logic                  split_q, split_d;
`else
    logic                  mis_q, mis_d;
`endif

    logic                  second_half;
    logic                  ram_en;
    logic [WordW-1:0]      word0;
    logic [WordW-1:0]      word1;
    logic [1:0]            lane_be;
    logic [15:0]           lane_wdata;
    logic [15:0]           rd_next;

    assign word0 = addr_q[ADDR_WIDTH-1:1];
    assign word1 = word0 + WordW'(1); // wraps modulo the word space

`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
    assign second_half = (state_q == StAcc1) || (state_q == StWait1);
`else
    assign second_half = 1'b0;
`endif

    spark80_byte_lane_steer u_steer (
        .acc_sz_i      (sz_q),
        .addr_lsb_i    (addr_q[0]),
        .second_half_i (second_half),
        .cpu_wdata_i   (wdata_q),
        .ram_rdata_i   (bus.ram_rdata),
        .rd_prev_i     (acc_q),
        .ram_be_o      (lane_be),
        .ram_wdata_o   (lane_wdata),
        .rd_next_o     (rd_next)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sz_d    = sz_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
        split_d = split_q;
`else
        mis_d   = mis_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.req_rdwr) begin
                    addr_d  = bus.data_inout_addr;
                    sz_d    = bus.data_acc_sz;
                    we_d    = bus.data_inout_we;
                    wdata_d = bus.temp_data_out;
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
                    split_d = is_split(bus.data_acc_sz, bus.data_inout_addr[0]);
`else
                    mis_d   = is_split(bus.data_acc_sz, bus.data_inout_addr[0]);
                    if (bus.data_acc_sz == cpu_data_acc_sz_16) begin
                        addr_d[0] = 1'b0;
                    end
`endif
                    state_d = StAcc0;
                end
            end
            StAcc0: begin
                cnt_d   = CntLoad;
                state_d = StWait0;
            end
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
            StAcc1: begin
                cnt_d   = CntLoad;
                state_d = StWait1;
            end
            StWait0, StWait1: begin
`else
            StWait0: begin
`endif
                // RAM data is valid once RAM_LATENCY cycles have elapsed, i.e.
                // when WAIT_STATES cycles remain on the counter.
                if ((cnt_q == CntCapture) && !we_q) begin
                    acc_d = rd_next;
                end
                if (cnt_q == 4'd0) begin
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
                    if ((state_q == StWait0) && split_q) begin
                        state_d = StAcc1;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                    if ((state_d == StDone) && !we_q) begin
                        rdata_d = acc_d;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            sz_q    <= cpu_data_acc_sz_8;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
            split_q <= 1'b0;
`else
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sz_q    <= sz_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
`ifdef SPARK80_MEM_BRIDGE_UNALIGNED_EN
            split_q <= split_d;
`else
            mis_q   <= mis_d;
`endif
        end
    end

    assign ram_en           = (state_q == StAcc0) || (state_q == StAcc1);
    assign bus.ram_en       = ram_en;
    assign bus.ram_we       = ram_en && we_q;
    assign bus.ram_be       = ram_en ? lane_be : BE_NONE;
    assign bus.ram_addr     = second_half ? word1 : word0;
    assign bus.ram_wdata    = lane_wdata;
    assign bus.data_ready   = (state_q == StDone);
    assign bus.temp_data_in = rdata_q;
`ifndef SPARK80_MEM_BRIDGE_UNALIGNED_EN
    assign misalign         = (state_q == StAcc0) && mis_q;
`endif

endmodule
